// File: rtl/instr_fetch_issue.sv
// Multi-cycle instruction fetch/issue unit: fetches words over a req/ready
// handshake, holds them in an IR and issues OpCode/Operands to the decoder.
module instr_fetch_issue #(
  parameter int INSTR_W  = 16,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  output logic                 ImemReq,
  output logic [ADDR_W-1:0]    ImemAddr,
  input  logic                 ImemReady,
  input  logic [INSTR_W-1:0]   ImemRdata,
  output logic                 InstrValid,
  input  logic                 InstrReady,
  output logic [2:0]           OpCode,
  output logic [INSTR_W-4:0]   Operands,
  output logic [ADDR_W-1:0]    PC,
  input  logic                 Redirect,
  input  logic [ADDR_W-1:0]    RedirectPC,
  output logic                 Halted
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

  state_t               r_state;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_ir;
  logic                 r_imem_req;
  logic                 r_instr_valid;
  logic                 r_halted;

  logic                 w_halt_word;
  logic [ADDR_W-1:0]    w_pc_inc;

  assign w_halt_word = &ImemRdata;
  assign w_pc_inc    = r_pc + 1'b1;

  // Handshake outputs are registered alongside the state so no input reaches
  // an output combinationally.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC_V;
      r_ir          <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Redirect) r_pc <= RedirectPC;
          if (Start) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
          end
        end

        S_FETCH: begin
          // Redirect wins over the memory handshake; the returned word is dropped.
          if (Redirect) begin
            r_pc <= RedirectPC;
          end else if (ImemReady) begin
            r_ir       <= ImemRdata;
            r_imem_req <= 1'b0;
            if (w_halt_word) begin
              r_state  <= S_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state       <= S_ISSUE;
              r_instr_valid <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          if (Redirect || InstrReady) begin
            r_pc          <= Redirect ? RedirectPC : w_pc_inc;
            r_state       <= S_FETCH;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
          end
        end

        S_HALTED: begin
          r_halted <= 1'b1;
        end

        default: begin
          r_state       <= S_IDLE;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign ImemReq    = r_imem_req;
  assign ImemAddr   = r_pc;
  assign PC         = r_pc;
  assign InstrValid = r_instr_valid;
  assign Halted     = r_halted;
  assign OpCode     = r_ir[INSTR_W-1 -: 3];
  assign Operands   = r_ir[INSTR_W-4:0];

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Bench for instr_fetch_issue: directed vector table, hand sequences for the
// wait/redirect corners, then random traffic against a behavioural model.
module tb_instr_fetch_issue;

  logic        clk = 1'b0;
  logic        reset, Start, ImemReady, InstrReady, Redirect;
  logic [15:0] ImemRdata;
  logic [7:0]  RedirectPC;
  logic        ImemReq, InstrValid, Halted;
  logic [7:0]  ImemAddr, PC;
  logic [2:0]  OpCode;
  logic [12:0] Operands;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_issue dut (
    .clk(clk), .reset(reset), .Start(Start),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemReady(ImemReady), .ImemRdata(ImemRdata),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .OpCode(OpCode), .Operands(Operands),
    .PC(PC), .Redirect(Redirect), .RedirectPC(RedirectPC), .Halted(Halted)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic st, input logic mrdy, input logic [15:0] rdata,
                       input logic irdy, input logic redir, input logic [7:0] rpc);
    reset = rst; Start = st; ImemReady = mrdy; ImemRdata = rdata;
    InstrReady = irdy; Redirect = redir; RedirectPC = rpc;
  endtask

  // Drive at the falling edge, let the rising edge act, sample 1 time unit later.
  task automatic step(input logic rst, input logic st, input logic mrdy, input logic [15:0] rdata,
                      input logic irdy, input logic redir, input logic [7:0] rpc);
    @(negedge clk);
    drive(rst, st, mrdy, rdata, irdy, redir, rpc);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, st, mrdy; logic [15:0] rdata; logic irdy, redir; logic [7:0] rpc;
    logic e_req, e_valid, e_chk_ir; logic [2:0] e_op; logic [12:0] e_opnd;
    logic [7:0] e_pc; logic e_halt;
  } vec_t;

  vec_t vecs [16];

  // Behavioural model for the random phase.
  logic [15:0] mem [256];
  bit          m_fetch, m_issue, m_halt;
  logic [7:0]  m_pc;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'h0);

    //           rst st  mrdy rdata     irdy red rpc    req val chk op    opnd      pc    halt
    vecs[0]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,3'd0,13'h0000,8'h00,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,3'd0,13'h0000,8'h00,1'b0};
    vecs[2]  = '{1'b0,1'b0,1'b1,16'h0123,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,3'd0,13'h0123,8'h00,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1,1'b0,8'h00, 1'b1,1'b0,1'b0,3'd0,13'h0000,8'h01,1'b0};
    vecs[4]  = '{1'b0,1'b0,1'b1,16'h8ABC,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,3'd4,13'h0ABC,8'h01,1'b0};
    vecs[5]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,3'd4,13'h0ABC,8'h01,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,3'd4,13'h0ABC,8'h01,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,3'd4,13'h0ABC,8'h01,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1,1'b0,8'h00, 1'b1,1'b0,1'b0,3'd0,13'h0000,8'h02,1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b1,16'h1111,1'b0,1'b1,8'hFF, 1'b1,1'b0,1'b0,3'd0,13'h0000,8'hFF,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b1,16'h2222,1'b0,1'b0,8'h00, 1'b0,1'b1,1'b1,3'd1,13'h0222,8'hFF,1'b0};
    vecs[11] = '{1'b0,1'b0,1'b0,16'h0000,1'b1,1'b0,8'h00, 1'b1,1'b0,1'b0,3'd0,13'h0000,8'h00,1'b0};
    vecs[12] = '{1'b0,1'b0,1'b0,16'hFFFF,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,3'd0,13'h0000,8'h00,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b1,16'hFFFF,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,3'd0,13'h0000,8'h00,1'b1};
    vecs[14] = '{1'b0,1'b1,1'b1,16'h0123,1'b1,1'b1,8'h40, 1'b0,1'b0,1'b0,3'd0,13'h0000,8'h00,1'b1};
    vecs[15] = '{1'b1,1'b0,1'b0,16'h0000,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,3'd0,13'h0000,8'h00,1'b0};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].mrdy, vecs[i].rdata, vecs[i].irdy, vecs[i].redir, vecs[i].rpc);
      check($sformatf("vec%0d ImemReq", i), 32'(ImemReq), 32'(vecs[i].e_req));
      check($sformatf("vec%0d InstrValid", i), 32'(InstrValid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d PC", i), 32'(PC), 32'(vecs[i].e_pc));
      check($sformatf("vec%0d ImemAddr", i), 32'(ImemAddr), 32'(vecs[i].e_pc));
      check($sformatf("vec%0d Halted", i), 32'(Halted), 32'(vecs[i].e_halt));
      if (vecs[i].e_chk_ir) begin
        check($sformatf("vec%0d OpCode", i), 32'(OpCode), 32'(vecs[i].e_op));
        check($sformatf("vec%0d Operands", i), 32'(Operands), 32'(vecs[i].e_opnd));
      end
    end

    // Memory wait states at PC=5: request and address held for 5 cycles.
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 8'h05);
    check("idle redirect PC", 32'(PC), 32'h05);
    check("idle redirect no req", 32'(ImemReq), 32'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("wait%0d ImemReq", k), 32'(ImemReq), 32'h1);
      check($sformatf("wait%0d ImemAddr", k), 32'(ImemAddr), 32'h05);
      check($sformatf("wait%0d InstrValid", k), 32'(InstrValid), 32'h0);
      if (k < 4) step(1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 8'h00);
    end
    step(1'b0, 1'b0, 1'b1, 16'h3005, 1'b0, 1'b0, 8'h00);
    check("wait done InstrValid", 32'(InstrValid), 32'h1);
    check("wait done OpCode", 32'(OpCode), 32'h1);
    check("wait done Operands", 32'(Operands), 32'h1005);

    // Redirect in ISSUE alongside acceptance: PC takes the target, not PC+1.
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 8'h40);
    check("issue redirect PC", 32'(PC), 32'h40);
    check("issue redirect valid", 32'(InstrValid), 32'h0);
    check("issue redirect req", 32'(ImemReq), 32'h1);
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 8'h00);
    check("issue redirect stays fetch", 32'(InstrValid), 32'h0);

    // Random phase.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 31) == 0) ? 16'hFFFF : 16'($urandom);
    begin
      int halt_cycles = 0;
      logic rst, st, mrdy, irdy, redir;
      logic [7:0]  rpc;
      logic [15:0] rdata;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        @(negedge clk);
        if (cyc > 0) begin
          check("rnd ImemReq", 32'(ImemReq), 32'(m_fetch));
          check("rnd InstrValid", 32'(InstrValid), 32'(m_issue));
          check("rnd Halted", 32'(Halted), 32'(m_halt));
          check("rnd PC", 32'(PC), 32'(m_pc));
          check("rnd ImemAddr", 32'(ImemAddr), 32'(m_pc));
          if (m_issue) begin
            check("rnd OpCode", 32'(OpCode), 32'(mem[m_pc][15:13]));
            check("rnd Operands", 32'(Operands), 32'(mem[m_pc][12:0]));
          end
        end
        halt_cycles = m_halt ? halt_cycles + 1 : 0;
        rst   = (cyc == 0) || ($urandom_range(0, 299) == 0) || (halt_cycles > 5);
        st    = ($urandom_range(0, 9) < 3);
        mrdy  = ($urandom_range(0, 9) < 7);
        irdy  = ($urandom_range(0, 9) < 6);
        redir = ($urandom_range(0, 9) == 0);
        rpc   = 8'($urandom);
        if (mrdy && redir)  rdata = 16'hFFFF;
        else if (mrdy)      rdata = mem[m_pc];
        else                rdata = 16'($urandom);
        drive(rst, st, mrdy, rdata, irdy, redir, rpc);

        if (rst) begin
          m_fetch = 0; m_issue = 0; m_halt = 0; m_pc = 8'h00;
        end else if (m_halt) begin
          m_halt = 1;
        end else if (m_fetch) begin
          if (redir) m_pc = rpc;
          else if (mrdy) begin
            m_fetch = 0;
            if (mem[m_pc] == 16'hFFFF) m_halt = 1;
            else m_issue = 1;
          end
        end else if (m_issue) begin
          if (redir || irdy) begin
            m_pc = redir ? rpc : m_pc + 8'd1;
            m_issue = 0; m_fetch = 1;
          end
        end else begin
          if (redir) m_pc = rpc;
          if (st) m_fetch = 1;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Multi-cycle instruction fetch and issue unit, the producer side of the 3-bit opcode interface consumed by the CPU control decoder.
- Fetches instruction words from instruction memory over a req/ready handshake and holds them in an instruction register.
- Splits each word into OpCode and operand fields and presents them to the decoder/datapath with a valid/ready handshake.
- Maintains the program counter, accepts redirects, and stops on a HALT word.

Parameters:
- INSTR_W, 16, instruction word width; OpCode is bits [INSTR_W-1:INSTR_W-3], operands are bits [INSTR_W-4:0].
- ADDR_W, 8, instruction address / PC width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  begin fetching from the current PC; sampled only in IDLE.
- ImemReq  output  1  fetch request to instruction memory.
- ImemAddr  output  ADDR_W  fetch address; equals PC.
- ImemReady  input  1  memory returns ImemRdata this cycle; the handshake completes on ImemReq & ImemReady.
- ImemRdata  input  INSTR_W  fetched instruction word.
- InstrValid  output  1  OpCode/Operands valid to the decoder.
- InstrReady  input  1  datapath accepts the instruction this cycle.
- OpCode  output  3  opcode field of the issued instruction.
- Operands  output  INSTR_W-3  remaining fields of the issued instruction.
- PC  output  ADDR_W  address of the instruction held or being fetched.
- Redirect  input  1  load a new PC (branch/jump).
- RedirectPC  input  ADDR_W  target used when Redirect=1.
- Halted  output  1  HALT word fetched; unit stopped.

Behaviour:
- Reset (sync, highest priority):
  - state=IDLE, PC=RESET_PC, IR=0.
  - ImemReq=0, InstrValid=0, OpCode=0, Operands=0, Halted=0.
  - Reset mid-fetch or mid-issue discards all in-flight data.
- All outputs are registered or decoded from state/IR only; there is no combinational path from input to output.
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE:
  - All handshake outputs are 0.
  - Start=1 -> FETCH on the next cycle.
  - Redirect in IDLE updates PC; the unit stays in IDLE.
- FETCH:
  - ImemReq=1, ImemAddr=PC.
  - Held until ImemReady=1; the number of wait cycles is unbounded.
  - On handshake: IR<=ImemRdata.
  - If ImemRdata is all ones (HALT word) -> HALTED; otherwise -> ISSUE.
- ISSUE:
  - InstrValid=1; OpCode and Operands come from IR.
  - OpCode, Operands and PC are held stable while InstrValid=1 and InstrReady=0.
  - On InstrValid & InstrReady: PC<=PC+1, wrapping modulo 2^ADDR_W (all ones -> 0), then -> FETCH.
- HALTED:
  - Halted=1, ImemReq=0, InstrValid=0.
  - Start and Redirect are ignored; only reset exits.
  - The HALT word is never issued.
- Redirect in FETCH or ISSUE (priority over both handshakes in the same cycle):
  - PC<=RedirectPC; state -> FETCH.
  - A same-cycle ImemReady word is discarded (no HALT detection on it).
  - A same-cycle InstrReady acceptance still counts for the datapath, but PC is not incremented.
  - InstrValid=0 on the next cycle.
- Throughput: minimum 2 cycles per instruction (FETCH + ISSUE) with zero-wait memory and InstrReady tied to 1.
- Latency: Start at cycle N -> ImemReq=1 at N+1 -> InstrValid=1 at N+2 if ImemReady=1 at N+1.

Test Plan:
- Reset, then Start=1 at cycle 1; memory always ready returning 16'h0123 at addr 0 -> ImemReq=1/ImemAddr=0 at cycle 2, InstrValid=1, OpCode=3'b000, Operands=13'h0123 at cycle 3, PC=1 after acceptance.
- ImemReady held low for 4 cycles at PC=5 -> ImemReq and ImemAddr=5 stable for 5 cycles; InstrValid=1 only after the ready cycle.
- STORE word 16'h8ABC in ISSUE with InstrReady=0 for 3 cycles -> OpCode=3'b100, Operands=13'h0ABC, PC unchanged for all 3 cycles; single PC increment on the accept cycle.
- PC=8'hFF, instruction accepted -> PC wraps to 0; next ImemAddr=0.
- Redirect=1, RedirectPC=8'h40 in the same cycle as ImemReady=1 -> fetched word dropped; next ImemReq with ImemAddr=8'h40; InstrValid stays 0 until that fetch completes.
- Fetch of 16'hFFFF -> Halted=1 next cycle, InstrValid never asserted, Start ignored; reset=1 for one cycle -> Halted=0, PC=RESET_PC, state IDLE.
